// File: rtl/icap_stream_ctrl.sv
// icap_stream_ctrl: ICAPE2 bitstream writer and counted readback.
// Write words pass a FIFO; readback is credit-limited into an output FIFO.
module icap_stream_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int WFIFO_DEPTH  = 16,
  parameter int RFIFO_DEPTH  = 8,
  parameter int READ_LATENCY = 3,
  parameter bit BIT_SWAP     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic                  rd_start,
  input  logic [15:0]           rd_count,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  icap_csib,
  output logic                  icap_rdwrb,
  output logic [DATA_WIDTH-1:0] icap_i,
  input  logic [DATA_WIDTH-1:0] icap_o
);
  localparam int WAW = $clog2(WFIFO_DEPTH);
  localparam int RAW = $clog2(RFIFO_DEPTH);
  localparam logic [WAW:0] WONE = 1;
  localparam logic [RAW:0] RONE = 1;
  localparam logic [RAW+1:0] RCAP = (RAW+2)'(RFIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, WRITE, RD_SW, RD_ISSUE, RD_DRAIN, RD_END
  } state_e;

  function automatic logic [DATA_WIDTH-1:0] swap(
    input logic [DATA_WIDTH-1:0] w
  );
    logic [DATA_WIDTH-1:0] r;
    r = w;
    if (BIT_SWAP)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        for (int k = 0; k < 8; k++)
          r[8*b+k] = w[8*b+7-k];
    return r;
  endfunction

  state_e state_q, state_d;
  logic csib_q, csib_d, rdwrb_q, rdwrb_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] icapi_q, icapi_d;
  logic [15:0] rem_q, rem_d;
  logic [RAW:0] infl_q;
  logic [READ_LATENCY:0] tag_q;
  logic issue;

  logic [DATA_WIDTH:0] wmem [WFIFO_DEPTH];
  logic [WAW:0] wwp_q, wrp_q;
  logic wfull, wempty, wpush, wpop, wlast;
  logic [DATA_WIDTH-1:0] wdata;

  assign wempty = wwp_q == wrp_q;
  assign wfull = (wwp_q[WAW] != wrp_q[WAW]) &&
                 (wwp_q[WAW-1:0] == wrp_q[WAW-1:0]);
  assign s_ready = !wfull && !RST;
  assign wpush = s_valid && s_ready;
  assign {wlast, wdata} = wmem[wrp_q[WAW-1:0]];

  logic [DATA_WIDTH-1:0] rmem [RFIFO_DEPTH];
  logic [RAW:0] rwp_q, rrp_q, rocc;
  logic [RAW+1:0] used;
  logic rpush, rpop;

  assign rocc = rwp_q - rrp_q;
  assign used = {1'b0, rocc} + {1'b0, infl_q};
  assign m_valid = rwp_q != rrp_q;
  assign m_data = rmem[rrp_q[RAW-1:0]];
  assign rpop = m_valid && m_ready;
  // tag_q[k] marks the cycle k after an enable reached the primitive
  assign rpush = tag_q[READ_LATENCY];

  assign busy = state_q != IDLE;
  assign done = done_q;
  assign icap_csib = csib_q;
  assign icap_rdwrb = rdwrb_q;
  assign icap_i = icapi_q;

  always_comb begin
    state_d = state_q;
    csib_d = 1'b1;
    rdwrb_d = rdwrb_q;
    icapi_d = icapi_q;
    done_d = 1'b0;
    rem_d = rem_q;
    wpop = 1'b0;
    issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdwrb_d = 1'b0;
        if (!wempty) begin
          state_d = WRITE;
        end else if (rd_start) begin
          if (rd_count == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d = rd_count;
            state_d = RD_SW;
          end
        end
      end
      WRITE: begin
        rdwrb_d = 1'b0;
        if (!wempty) begin
          wpop = 1'b1;
          csib_d = 1'b0;
          icapi_d = swap(wdata);
          if (wlast) begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end
      end
      RD_SW: begin
        rdwrb_d = 1'b1;
        state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        rdwrb_d = 1'b1;
        if (used < RCAP) begin
          issue = 1'b1;
          csib_d = 1'b0;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        rdwrb_d = 1'b1;
        if (infl_q == '0) state_d = RD_END;
      end
      RD_END: begin
        rdwrb_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      csib_q <= 1'b1;
      rdwrb_q <= 1'b0;
      icapi_q <= '0;
      done_q <= 1'b0;
      rem_q <= '0;
      infl_q <= '0;
      tag_q <= '0;
      wwp_q <= '0;
      wrp_q <= '0;
      rwp_q <= '0;
      rrp_q <= '0;
    end else begin
      state_q <= state_d;
      csib_q <= csib_d;
      rdwrb_q <= rdwrb_d;
      icapi_q <= icapi_d;
      done_q <= done_d;
      rem_q <= rem_d;
      infl_q <= infl_q + {{RAW{1'b0}}, issue}
                       - {{RAW{1'b0}}, rpush};
      tag_q <= {tag_q[READ_LATENCY-1:0], issue};
      if (wpush) wwp_q <= wwp_q + WONE;
      if (wpop) wrp_q <= wrp_q + WONE;
      if (rpush) rwp_q <= rwp_q + RONE;
      if (rpop) rrp_q <= rrp_q + RONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (wpush) wmem[wwp_q[WAW-1:0]] <= {s_last, s_data};
    if (rpush) rmem[rwp_q[RAW-1:0]] <= swap(icap_o);
  end

  // direction may only flip while the primitive is deselected
  a_rdwrb: assert property (@(posedge CLK) disable iff (RST)
    (rdwrb_d != rdwrb_q) |-> (csib_q && csib_d));

endmodule

// File: tb/tb_icap_stream_ctrl.sv
// tb_icap_stream_ctrl: random and directed checks of icap_stream_ctrl
// against a queue scoreboard and a behavioural ICAPE2 read model.
module tb_icap_stream_ctrl;
  localparam int LAT = 3;
  localparam int RD = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic rd_start = 1'b0;
  logic [15:0] rd_count = '0;
  logic [31:0] m_data;
  logic m_valid, m_ready, busy, done;
  logic icap_csib, icap_rdwrb;
  logic [31:0] icap_i;
  logic [31:0] icap_o = '0;

  icap_stream_ctrl dut (
    .CLK(CLK), .RST(RST),
    .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .s_last(s_last),
    .rd_start(rd_start), .rd_count(rd_count),
    .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb),
    .icap_i(icap_i), .icap_o(icap_o)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        r[8*b+7-k] = w[8*b+k];
    return r;
  endfunction

  logic [31:0] acc_q[$], wr_q[$], rb_q[$], m_q[$];
  int wr_cyc[$];
  int ncyc = 0, n_en = 0, done_cnt = 0, out_cnt = 0;
  logic [31:0] sched_d [64];
  bit sched_v [64];
  logic pcsib = 1'b1, prdwrb = 1'b0, prst = 1'b1;

  // monitor + ICAPE2 read model: data appears LAT cycles after enable
  always @(negedge CLK) begin
    logic [31:0] w;
    ncyc++;
    if (RST) begin
      for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
      out_cnt = 0;
      icap_o = $urandom();
    end else begin
      if (sched_v[ncyc % 64]) begin
        icap_o = sched_d[ncyc % 64];
        sched_v[ncyc % 64] = 1'b0;
      end else begin
        icap_o = $urandom();
      end
      if (!prst && icap_rdwrb !== prdwrb)
        chk("rdwrb_sw", {30'd0, pcsib, icap_csib}, 32'd3);
      if (!icap_csib && !icap_rdwrb) begin
        wr_q.push_back(icap_i);
        wr_cyc.push_back(ncyc);
      end
      if (!icap_csib && icap_rdwrb) begin
        w = $urandom();
        rb_q.push_back(w);
        sched_d[(ncyc + LAT) % 64] = w;
        sched_v[(ncyc + LAT) % 64] = 1'b1;
        n_en++;
        out_cnt++;
        chk("credit", 32'(out_cnt <= RD), 1);
      end
      if (s_valid && s_ready) acc_q.push_back(bswap(s_data));
      if (m_valid && m_ready) begin
        m_q.push_back(m_data);
        out_cnt--;
      end
      if (done) done_cnt++;
    end
    pcsib = icap_csib;
    prdwrb = icap_rdwrb;
    prst = RST;
  end

  bit mr_rand = 1'b0;
  bit mr_force = 1'b0;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      m_ready = mr_rand ? 1'($urandom_range(0, 1)) : mr_force;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    int t;
    bit ok;
    s_data = d;
    s_last = last;
    s_valid = 1'b1;
    t = 0;
    do begin
      ok = s_ready;
      tick();
      t++;
    end while (!ok && t < 300);
    if (!ok) chk("send_timeout", 0, 1);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic rd_go(input logic [15:0] n);
    rd_count = n;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (done_cnt < n && t < budget) begin
      tick();
      t++;
    end
    chk("done_wait", 32'(done_cnt >= n), 1);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (m_valid && t < budget) begin
      tick();
      t++;
    end
    chk("drain", m_valid, 0);
  endtask

  task automatic cmp_wr(input int wb, input int ab, input int n);
    chk("wr_cnt", wr_q.size() - wb, n);
    chk("acc_cnt", acc_q.size() - ab, n);
    for (int i = 0; i < n; i++)
      if (wb + i < wr_q.size() && ab + i < acc_q.size())
        chk("wr_data", wr_q[wb+i], acc_q[ab+i]);
  endtask

  task automatic cmp_rd(input int mb, input int rbb, input int n);
    chk("rd_cnt", m_q.size() - mb, n);
    chk("rb_cnt", rb_q.size() - rbb, n);
    for (int i = 0; i < n; i++)
      if (mb + i < m_q.size() && rbb + i < rb_q.size())
        chk("rd_data", m_q[mb+i], bswap(rb_q[rbb+i]));
  endtask

  initial begin
    int wb, ab, mb, rbb, eb, db, idx, t0;
    int exp_done, exp_rd, op, n;
    logic [31:0] wd [20];

    // reset
    tick();
    chk("rst_csib", icap_csib, 1);
    chk("rst_rdwrb", icap_rdwrb, 0);
    chk("rst_icap_i", icap_i, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s_ready", s_ready, 0);
    tick();
    RST = 1'b0;
    #1;
    chk("s_ready_after_rst", s_ready, 1);
    tick();

    // directed three-word burst
    wb = wr_q.size(); db = done_cnt;
    send(32'hAA995566, 1'b0);
    send(32'h20000000, 1'b0);
    send(32'h30008001, 1'b1);
    wait_done(db + 1, 50);
    repeat (4) tick();
    chk("w3_cnt", wr_q.size() - wb, 3);
    if (wr_q.size() >= wb + 3) begin
      chk("w3_0", wr_q[wb], 32'h5599AA66);
      chk("w3_1", wr_q[wb+1], 32'h04000000);
      chk("w3_2", wr_q[wb+2], 32'h0C000180);
      chk("w3_consec", wr_cyc[wb+2] - wr_cyc[wb], 2);
    end
    chk("w3_done", done_cnt - db, 1);
    chk("w3_busy", busy, 0);

    // stalled writes with 2-cycle gaps
    wb = wr_q.size(); ab = acc_q.size();
    db = done_cnt; eb = n_en;
    for (int i = 0; i < 5; i++) begin
      send($urandom(), i == 4);
      repeat (2) tick();
    end
    wait_done(db + 1, 50);
    repeat (3) tick();
    cmp_wr(wb, ab, 5);
    chk("stall_done", done_cnt - db, 1);
    chk("stall_no_rd", n_en - eb, 0);

    // backpressure: readback stalls on credits while writes pile up
    wb = wr_q.size(); ab = acc_q.size();
    mb = m_q.size(); rbb = rb_q.size();
    db = done_cnt; eb = n_en;
    for (int i = 0; i < 20; i++) wd[i] = $urandom();
    mr_force = 1'b0;
    rd_go(16'd12);
    idx = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 40 && idx < 20; c++) begin
      bit ok;
      s_data = wd[idx];
      s_last = (idx == 19);
      ok = s_ready;
      tick();
      if (ok) idx++;
    end
    chk("bp_accepted", idx, 16);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_enables", n_en - eb, RD);
    mr_force = 1'b1;
    for (int c = 0; c < 400 && idx < 20; c++) begin
      bit ok;
      s_data = wd[idx];
      s_last = (idx == 19);
      ok = s_ready;
      tick();
      if (ok) idx++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("bp_all_in", idx, 20);
    wait_done(db + 2, 300);
    wait_drain(100);
    repeat (3) tick();
    cmp_wr(wb, ab, 20);
    if (acc_q.size() >= ab + 20)
      chk("bp_last", acc_q[ab+19], bswap(wd[19]));
    cmp_rd(mb, rbb, 12);

    // readback of 10 with no downstream ready
    mb = m_q.size(); rbb = rb_q.size();
    db = done_cnt; eb = n_en;
    mr_force = 1'b0;
    tick();
    rd_go(16'd10);
    repeat (40) tick();
    chk("rb10_enables", n_en - eb, RD);
    chk("rb10_csib", icap_csib, 1);
    chk("rb10_m_valid", m_valid, 1);
    mr_force = 1'b1;
    wait_done(db + 1, 200);
    wait_drain(100);
    repeat (3) tick();
    chk("rb10_total_en", n_en - eb, 10);
    chk("rb10_done", done_cnt - db, 1);
    cmp_rd(mb, rbb, 10);

    // zero-count readback: done only
    db = done_cnt; eb = n_en;
    rd_go(16'd0);
    repeat (3) tick();
    chk("rb0_done", done_cnt - db, 1);
    chk("rb0_en", n_en - eb, 0);
    chk("rb0_busy", busy, 0);

    // random mix of writes and readbacks
    wb = wr_q.size(); ab = acc_q.size();
    mb = m_q.size(); rbb = rb_q.size();
    db = done_cnt; eb = n_en;
    exp_done = 0; exp_rd = 0;
    mr_rand = 1'b1;
    t0 = ncyc;
    while (ncyc - t0 < 2000) begin
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
          send($urandom(), i == n - 1);
          repeat ($urandom_range(0, 2)) tick();
        end
        exp_done++;
        wait_done(db + exp_done, 300);
      end else if (op == 2) begin
        n = $urandom_range(0, 12);
        rd_go(16'(n));
        exp_done++;
        exp_rd += n;
        wait_done(db + exp_done, 600);
        wait_drain(300);
      end else begin
        send($urandom(), 1'b1);
        rd_go(16'd5);
        exp_done++;
        wait_done(db + exp_done, 300);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain(300);
    repeat (3) tick();
    mr_rand = 1'b0;
    chk("mix_done", done_cnt - db, exp_done);
    chk("mix_en", n_en - eb, exp_rd);
    cmp_wr(wb, ab, acc_q.size() - ab);
    cmp_rd(mb, rbb, exp_rd);

    // reset in the middle of a readback
    mr_force = 1'b0;
    tick();
    rd_go(16'd10);
    repeat (6) tick();
    RST = 1'b1;
    tick();
    chk("mrst_csib", icap_csib, 1);
    chk("mrst_rdwrb", icap_rdwrb, 0);
    chk("mrst_icap_i", icap_i, 0);
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_busy", busy, 0);
    RST = 1'b0;
    tick();
    wb = wr_q.size(); ab = acc_q.size();
    mb = m_q.size(); rbb = rb_q.size();
    db = done_cnt; eb = n_en;
    repeat (6) tick();
    chk("mrst_no_stale", m_valid, 0);
    chk("mrst_no_en", n_en - eb, 0);
    mr_force = 1'b1;
    send($urandom(), 1'b0);
    send($urandom(), 1'b1);
    wait_done(db + 1, 50);
    repeat (2) tick();
    rd_go(16'd3);
    wait_done(db + 2, 100);
    wait_drain(50);
    repeat (3) tick();
    cmp_wr(wb, ab, 2);
    cmp_rd(mb, rbb, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
